// File: rtl/crc_chk_pkg.sv
// Shared types, default CRC-16 constants and the unrolled LFSR step
// used by the parallel CRC checker.
package crc_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    CHECK = 2'd2
  } crc_state_e;

  localparam logic [15:0] CRC16_POLY      = 16'h8005;
  localparam logic [15:0] CRC16_SEED      = 16'hFFFF;
  localparam logic [15:0] CRC_EXPECT_ZERO = 16'h0000;

  localparam int CW_MAX = 32;
  localparam int DW_MAX = 64;

  // Applies the serial rule dw times, data[dw-1] first; all work is masked to cw bits.
  function automatic logic [CW_MAX-1:0] crc_step_f(
    input logic [CW_MAX-1:0] lfsr,
    input logic [DW_MAX-1:0] data,
    input logic [CW_MAX-1:0] poly,
    input int                cw,
    input int                dw
  );
    logic [CW_MAX-1:0] mask;
    logic [CW_MAX-1:0] acc;
    logic              fb;
    mask = (cw >= CW_MAX) ? {CW_MAX{1'b1}} : ((32'd1 << cw) - 32'd1);
    acc  = lfsr & mask;
    for (int i = DW_MAX - 1; i >= 0; i--) begin
      if (i < dw) begin
        fb  = data[i] ^ acc[cw-1];
        acc = ((acc << 1) ^ (fb ? (poly & mask) : '0)) & mask;
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/crc_chk_par_if.sv
// Receive-side bundle of the CRC checker: framed data in, frame result out.
interface crc_chk_par_if #(
  parameter int CW = 16,
  parameter int DW = 8
);
  logic [DW-1:0] data_in;
  logic          data_vld;
  logic          sof;
  logic          eof;
  logic          busy;
  logic          crc_done;
  logic          crc_err;
  logic [CW-1:0] residue;
  logic          frame_abort;
  logic [15:0]   err_cnt;

  modport master (
    output data_in, data_vld, sof, eof,
    input  busy, crc_done, crc_err, residue, frame_abort, err_cnt
  );

  modport slave (
    input  data_in, data_vld, sof, eof,
    output busy, crc_done, crc_err, residue, frame_abort, err_cnt
  );
endinterface

// File: rtl/crc_step_comb.sv
// Combinational next-LFSR value after absorbing DW data bits, MSB first.
module crc_step_comb
  import crc_chk_pkg::*;
#(
  parameter int          CW   = 16,
  parameter int          DW   = 8,
  parameter logic [31:0] POLY = 32'(CRC16_POLY)
) (
  input  logic [CW-1:0] lfsr_in,
  input  logic [DW-1:0] data_in,
  output logic [CW-1:0] lfsr_out
);
  logic [CW_MAX-1:0] step_full;

  assign step_full = crc_step_f(CW_MAX'(lfsr_in), DW_MAX'(data_in), POLY, CW, DW);
  assign lfsr_out  = step_full[CW-1:0];

  // Upper bits are always zero because the function masks to CW.
  if (CW < CW_MAX) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^step_full[CW_MAX-1:CW];
  end
endmodule

// File: rtl/crc_chk_par.sv
// Parallel CRC checker: DW bits/beat into a CW-bit LFSR, result pulse two edges after eof.
// Optional saturating error counter enabled by CRC_CHK_ERR_CNT_EN.
module crc_chk_par
  import crc_chk_pkg::*;
#(
  parameter int          CW     = 16,
  parameter int          DW     = 8,
  parameter logic [31:0] POLY   = 32'(CRC16_POLY),
  parameter logic [31:0] SEED   = 32'(CRC16_SEED),
  parameter logic [31:0] EXPECT = 32'(CRC_EXPECT_ZERO)
) (
  input  logic         sb_clk,
  input  logic         rst,
  crc_chk_par_if.slave bus
);
  localparam logic [CW-1:0] SEED_W   = SEED[CW-1:0];
  localparam logic [CW-1:0] EXPECT_W = EXPECT[CW-1:0];

  crc_state_e    state_q, state_d;
  logic [CW-1:0] lfsr_q, lfsr_d;
  logic [CW-1:0] step_base, step_out;
  logic          abort_d, chk_d;

  logic          chk_vld_q, chk_err_q;
  logic [CW-1:0] chk_res_q;
  logic          done_q, err_q, abort_q;
  logic [CW-1:0] res_q;

  // One step engine: restart and frame start seed from SEED, continuation from the LFSR.
  assign step_base = (state_q == ACCUM && !bus.sof) ? lfsr_q : SEED_W;

  crc_step_comb #(
    .CW  (CW),
    .DW  (DW),
    .POLY(32'(POLY[CW-1:0]))
  ) u_step (
    .lfsr_in (step_base),
    .data_in (bus.data_in),
    .lfsr_out(step_out)
  );

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    abort_d = 1'b0;
    chk_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.data_vld && bus.sof) begin
          lfsr_d  = step_out;
          state_d = bus.eof ? CHECK : ACCUM;
        end
      end
      ACCUM: begin
        if (bus.data_vld) begin
          lfsr_d  = step_out;
          abort_d = bus.sof;
          if (bus.eof) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        chk_d   = 1'b1;
        lfsr_d  = SEED_W;
        state_d = IDLE;
      end
      default: begin
        lfsr_d  = SEED_W;
        state_d = IDLE;
      end
    endcase
  end

  // The check stage feeds a result register, so crc_done lands on the second edge after eof.
  always_ff @(posedge sb_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED_W;
      abort_q   <= 1'b0;
      chk_vld_q <= 1'b0;
      chk_err_q <= 1'b0;
      chk_res_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      abort_q   <= abort_d;
      chk_vld_q <= chk_d;
      if (chk_d) begin
        chk_err_q <= (lfsr_q != EXPECT_W);
        chk_res_q <= lfsr_q;
      end
      done_q <= chk_vld_q;
      if (chk_vld_q) begin
        err_q <= chk_err_q;
        res_q <= chk_res_q;
      end
    end
  end

`ifdef CRC_CHK_ERR_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge sb_clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (chk_vld_q && chk_err_q && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.err_cnt = cnt_q;
`else
  assign bus.err_cnt = 16'd0;
`endif

  assign bus.busy        = (state_q == ACCUM);
  assign bus.crc_done    = done_q;
  assign bus.crc_err     = err_q;
  assign bus.residue     = res_q;
  assign bus.frame_abort = abort_q;
endmodule

// File: tb/tb_crc_chk_par.sv
// Directed bench for crc_chk_par at DW=8, DW=1 and DW=32 with CRC-16 defaults.
module tb_crc_chk_par;
  logic sb_clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   done8 = 0, abort8 = 0;

  always #5 sb_clk = ~sb_clk;

  crc_chk_par_if #(.CW(16), .DW(8))  if8();
  crc_chk_par_if #(.CW(16), .DW(1))  if1();
  crc_chk_par_if #(.CW(16), .DW(32)) if32();

  crc_chk_par #(.CW(16), .DW(8))  u_dut8  (.sb_clk(sb_clk), .rst(rst), .bus(if8));
  crc_chk_par #(.CW(16), .DW(1))  u_dut1  (.sb_clk(sb_clk), .rst(rst), .bus(if1));
  crc_chk_par #(.CW(16), .DW(32)) u_dut32 (.sb_clk(sb_clk), .rst(rst), .bus(if32));

  logic [2:0]  done_v;
  logic [2:0]  err_v;
  logic [15:0] res_v [3];
  assign done_v   = {if32.crc_done, if1.crc_done, if8.crc_done};
  assign err_v    = {if32.crc_err, if1.crc_err, if8.crc_err};
  assign res_v[0] = if8.residue;
  assign res_v[1] = if1.residue;
  assign res_v[2] = if32.residue;

  always @(negedge sb_clk) begin
    if (if8.crc_done === 1'b1) done8++;
    if (if8.frame_abort === 1'b1) abort8++;
  end

`ifdef CRC_CHK_ERR_CNT_EN
  localparam logic [15:0] ERRCNT_AFTER_ONE = 16'd1;
`else
  localparam logic [15:0] ERRCNT_AFTER_ONE = 16'd0;
`endif

  // Independent bit-serial reference: bits[n-1] is consumed first.
  function automatic logic [15:0] model_crc(input logic [127:0] bits, input int n);
    logic [15:0] l;
    logic        fb;
    l = 16'hFFFF;
    for (int i = n - 1; i >= 0; i--) begin
      fb = bits[i] ^ l[15];
      l  = {l[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    return l;
  endfunction

  task automatic step();
    @(posedge sb_clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] d, input logic s, input logic e);
    if8.data_in = d; if8.data_vld = 1'b1; if8.sof = s; if8.eof = e;
    step();
    if8.data_vld = 1'b0; if8.sof = 1'b0; if8.eof = 1'b0;
  endtask

  task automatic send1(input logic d, input logic s, input logic e);
    if1.data_in = d; if1.data_vld = 1'b1; if1.sof = s; if1.eof = e;
    step();
    if1.data_vld = 1'b0; if1.sof = 1'b0; if1.eof = 1'b0;
  endtask

  task automatic send32(input logic [31:0] d, input logic s, input logic e);
    if32.data_in = d; if32.data_vld = 1'b1; if32.sof = s; if32.eof = e;
    step();
    if32.data_vld = 1'b0; if32.sof = 1'b0; if32.eof = 1'b0;
  endtask

  // Sends 11 bytes of fr; counts cycles with busy low during the inserted gaps.
  task automatic send_frame8(input logic [87:0] fr, input int gap, output int busy_lo);
    busy_lo = 0;
    for (int k = 0; k < 11; k++) begin
      send8(fr[87-8*k -: 8], k == 0, k == 10);
      if (k != 10) begin
        for (int g = 0; g < gap; g++) begin
          if (if8.busy !== 1'b1) busy_lo++;
          step();
        end
      end
    end
  endtask

  // lat = edges after the eof-sampling edge until crc_done is seen, -1 on timeout.
  task automatic wait_done(input int sel, output int lat, output logic err, output logic [15:0] res);
    lat = -1; err = 1'bx; res = 'x;
    for (int i = 0; i <= 8; i++) begin
      if (done_v[sel] === 1'b1) begin
        lat = i; err = err_v[sel]; res = res_v[sel];
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (if8.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", if8.busy); end
    checks++; if (if8.crc_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", if8.crc_done); end
    checks++; if (if8.crc_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", if8.crc_err); end
    checks++; if (if8.residue !== 16'h0000) begin failures++; $display("FAIL reset_residue got=%h exp=0000", if8.residue); end
    checks++; if (if8.frame_abort !== 1'b0) begin failures++; $display("FAIL reset_abort got=%b exp=0", if8.frame_abort); end
    checks++; if (if8.err_cnt !== 16'h0000) begin failures++; $display("FAIL reset_errcnt got=%h exp=0000", if8.err_cnt); end
    checks++; if (if32.residue !== 16'h0000) begin failures++; $display("FAIL reset_residue32 got=%h exp=0000", if32.residue); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_good_frame();
    logic [87:0] fr;
    int lat, blo, d0;
    logic err;
    logic [15:0] res;
    fr = 88'h313233343536373839AEE7;
    send8(8'h55, 1'b0, 1'b0);
    checks++; if (if8.busy !== 1'b0) begin failures++; $display("FAIL good_nosof_ignored busy=%b exp=0", if8.busy); end
    d0 = done8;
    send8(fr[87:80], 1'b1, 1'b0);
    checks++; if (if8.busy !== 1'b1) begin failures++; $display("FAIL good_busy_after_sof got=%b exp=1", if8.busy); end
    for (int k = 1; k < 11; k++) send8(fr[87-8*k -: 8], 1'b0, k == 10);
    checks++; if (if8.crc_done !== 1'b0) begin failures++; $display("FAIL good_done_early got=%b exp=0", if8.crc_done); end
    wait_done(0, lat, err, res);
    checks++; if (lat !== 2) begin failures++; $display("FAIL good_latency got=%0d exp=2", lat); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL good_err got=%b exp=0", err); end
    checks++; if (res !== 16'h0000) begin failures++; $display("FAIL good_residue got=%h exp=0000", res); end
    checks++; if (if8.busy !== 1'b0) begin failures++; $display("FAIL good_busy_end got=%b exp=0", if8.busy); end
    step();
    checks++; if (if8.crc_done !== 1'b0) begin failures++; $display("FAIL good_done_pulse got=%b exp=0", if8.crc_done); end
    step(); step();
    checks++; if (done8 - d0 !== 1) begin failures++; $display("FAIL good_done_count got=%0d exp=1", done8 - d0); end
    blo = 0;
  endtask

  task automatic test_bit_error();
    logic [87:0] fr;
    int lat, blo;
    logic err;
    logic [15:0] res, exp_res;
    fr = 88'h313233343436373839AEE7;
    exp_res = model_crc({40'd0, fr}, 88);
    send_frame8(fr, 0, blo);
    wait_done(0, lat, err, res);
    checks++; if (lat !== 2) begin failures++; $display("FAIL biterr_latency got=%0d exp=2", lat); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL biterr_err got=%b exp=1", err); end
    checks++; if (res !== exp_res || res === 16'h0000) begin failures++; $display("FAIL biterr_residue got=%h exp=%h", res, exp_res); end
    step();
    checks++; if (if8.err_cnt !== ERRCNT_AFTER_ONE) begin failures++; $display("FAIL biterr_errcnt got=%h exp=%h", if8.err_cnt, ERRCNT_AFTER_ONE); end
    checks++; if (if8.crc_err !== 1'b1) begin failures++; $display("FAIL biterr_err_held got=%b exp=1", if8.crc_err); end
    step();
  endtask

  task automatic test_gaps();
    logic [87:0] fr;
    int lat, blo;
    logic err;
    logic [15:0] res;
    fr = 88'h313233343536373839AEE7;
    send_frame8(fr, 3, blo);
    checks++; if (blo !== 0) begin failures++; $display("FAIL gaps_busy_drop got=%0d exp=0", blo); end
    wait_done(0, lat, err, res);
    checks++; if (lat !== 2) begin failures++; $display("FAIL gaps_latency got=%0d exp=2", lat); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL gaps_err got=%b exp=0", err); end
    checks++; if (res !== 16'h0000) begin failures++; $display("FAIL gaps_residue got=%h exp=0000", res); end
    step();
  endtask

  task automatic test_restart();
    logic [87:0] fr;
    int lat, d0, a0;
    logic err;
    logic [15:0] res;
    fr = 88'h313233343536373839AEE7;
    d0 = done8; a0 = abort8;
    send8(8'h31, 1'b1, 1'b0); send8(8'h32, 1'b0, 1'b0);
    send8(8'h33, 1'b0, 1'b0); send8(8'h34, 1'b0, 1'b0);
    checks++; if (if8.frame_abort !== 1'b0) begin failures++; $display("FAIL restart_abort_early got=%b exp=0", if8.frame_abort); end
    send8(fr[87:80], 1'b1, 1'b0);
    checks++; if (if8.frame_abort !== 1'b1) begin failures++; $display("FAIL restart_abort_pulse got=%b exp=1", if8.frame_abort); end
    for (int k = 1; k < 11; k++) send8(fr[87-8*k -: 8], 1'b0, k == 10);
    wait_done(0, lat, err, res);
    checks++; if (lat !== 2) begin failures++; $display("FAIL restart_latency got=%0d exp=2", lat); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL restart_err got=%b exp=0", err); end
    checks++; if (res !== 16'h0000) begin failures++; $display("FAIL restart_residue got=%h exp=0000", res); end
    step(); step();
    checks++; if (done8 - d0 !== 1) begin failures++; $display("FAIL restart_done_count got=%0d exp=1", done8 - d0); end
    checks++; if (abort8 - a0 !== 1) begin failures++; $display("FAIL restart_abort_count got=%0d exp=1", abort8 - a0); end
  endtask

  task automatic test_reset_mid();
    logic [87:0] fr;
    int lat, blo, d0;
    logic err;
    logic [15:0] res;
    fr = 88'h313233343536373839AEE7;
    d0 = done8;
    send8(8'h31, 1'b1, 1'b0); send8(8'h32, 1'b0, 1'b0); send8(8'h33, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (if8.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", if8.busy); end
    for (int i = 0; i < 5; i++) step();
    checks++; if (done8 - d0 !== 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", done8 - d0); end
    send_frame8(fr, 0, blo);
    wait_done(0, lat, err, res);
    checks++; if (lat !== 2) begin failures++; $display("FAIL rstmid_next_latency got=%0d exp=2", lat); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rstmid_next_err got=%b exp=0", err); end
    checks++; if (res !== 16'h0000) begin failures++; $display("FAIL rstmid_next_residue got=%h exp=0000", res); end
    step();
  endtask

  task automatic test_serial_equiv();
    logic [87:0] fr;
    logic [63:0] rnd;
    logic [31:0] word;
    logic [15:0] exp_rnd, exp_word, res;
    int lat;
    logic err;
    fr = 88'h313233343536373839AEE7;
    for (int i = 87; i >= 0; i--) send1(fr[i], i == 87, i == 0);
    wait_done(1, lat, err, res);
    checks++; if (lat !== 2) begin failures++; $display("FAIL serial_good_latency got=%0d exp=2", lat); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL serial_good_err got=%b exp=0", err); end
    checks++; if (res !== 16'h0000) begin failures++; $display("FAIL serial_good_residue got=%h exp=0000", res); end
    step();

    rnd = 64'hC3A51F079E62D4B8;
    exp_rnd = model_crc({64'd0, rnd}, 64);
    for (int i = 63; i >= 0; i--) send1(rnd[i], i == 63, i == 0);
    wait_done(1, lat, err, res);
    checks++; if (res !== exp_rnd) begin failures++; $display("FAIL rnd_dw1_residue got=%h exp=%h", res, exp_rnd); end
    checks++; if (err !== (exp_rnd != 16'h0000)) begin failures++; $display("FAIL rnd_dw1_err got=%b", err); end
    step();
    for (int k = 0; k < 8; k++) send8(rnd[63-8*k -: 8], k == 0, k == 7);
    wait_done(0, lat, err, res);
    checks++; if (res !== exp_rnd) begin failures++; $display("FAIL rnd_dw8_residue got=%h exp=%h", res, exp_rnd); end
    step();
    send32(rnd[63:32], 1'b1, 1'b0);
    send32(rnd[31:0], 1'b0, 1'b1);
    wait_done(2, lat, err, res);
    checks++; if (lat !== 2) begin failures++; $display("FAIL rnd_dw32_latency got=%0d exp=2", lat); end
    checks++; if (res !== exp_rnd) begin failures++; $display("FAIL rnd_dw32_residue got=%h exp=%h", res, exp_rnd); end
    step();

    word = 32'h12345678;
    exp_word = model_crc({96'd0, word}, 32);
    send32(word, 1'b1, 1'b1);
    checks++; if (if32.busy !== 1'b0) begin failures++; $display("FAIL single_beat_busy got=%b exp=0", if32.busy); end
    wait_done(2, lat, err, res);
    checks++; if (lat !== 2) begin failures++; $display("FAIL single_beat_latency got=%0d exp=2", lat); end
    checks++; if (res !== exp_word) begin failures++; $display("FAIL single_beat_residue got=%h exp=%h", res, exp_word); end
    step();
  endtask

  initial begin
    rst = 1'b1;
    if8.data_in = '0;  if8.data_vld = 1'b0;  if8.sof = 1'b0;  if8.eof = 1'b0;
    if1.data_in = '0;  if1.data_vld = 1'b0;  if1.sof = 1'b0;  if1.eof = 1'b0;
    if32.data_in = '0; if32.data_vld = 1'b0; if32.sof = 1'b0; if32.eof = 1'b0;
    test_reset();
    test_good_frame();
    test_bit_error();
    test_gaps();
    test_restart();
    test_reset_mid();
    test_serial_equiv();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
